regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file; the next generation of the RV32I integer regfile.
//  Adds configurable width/depth/port count, write-to-read bypass and per-entry pending scoreboard.
//  Includes a post-reset clear sweep, so no $readmemh preload is needed.
//  Sits in decode (reads, issue) and writeback (writes) of the pipelined core.
// PARAMETERS
//  XLEN      32  data width of each entry
//  DEPTH     32  number of entries; AW = $clog2(DEPTH)
//  NUM_RD    2   read ports
//  NUM_WR    1   write ports
//  ZERO_REG  1   1: entry 0 reads 0, ignores writes, never pending
//  BYPASS    1   1: same-cycle write data forwarded to matching reads
// PORTS
//  clk      in   1            clock, rising edge
//  rst      in   1            async active-high reset
//  clr_req  in   1            request a new clear sweep (RUN only)
//  ready    out  1            1 in RUN; 0 in CLEAR
//  wr_en    in   NUM_WR       per-port write enable
//  wr_addr  in   NUM_WR*AW    flat write addresses, port p at [p*AW +: AW]
//  wr_data  in   NUM_WR*XLEN  flat write data
//  rd_addr  in   NUM_RD*AW    flat read addresses
//  rd_data  out  NUM_RD*XLEN  flat read data, combinational
//  iss_en   in   1            issue: mark iss_addr pending (result outstanding)
//  iss_addr in   AW           destination being issued
//  rd_pend  out  NUM_RD       pending bit of each rd_addr, combinational
// BEHAVIOUR
//  Reset:
//   rst=1 -> FSM=CLEAR, sweep index=0, all pending bits=0, ready=0.
//   Array contents are not reset asynchronously.
//  FSM:
//   CLEAR writes 0 to entry[idx] each cycle, idx++.
//   At idx==DEPTH-1, goes to RUN next cycle (DEPTH cycles total).
//   RUN + clr_req=1 -> CLEAR with idx=0; pending bits also cleared that edge.
//  In CLEAR:
//   rd_data=0, rd_pend=0; wr_en, iss_en and clr_req ignored.
//  Write (RUN):
//   Each port p with wr_en[p] writes entry at posedge, and clears pending[wr_addr[p]].
//   Same address on several ports: highest p wins.
//   ZERO_REG=1 and addr 0: write dropped.
//  Read:
//   rd_data = entry[rd_addr] combinationally.
//   BYPASS=1: a RUN-state write matching rd_addr that cycle returns wr_data (highest p).
//   BYPASS=0: returns the old value.
//   ZERO_REG=1 and addr 0: returns 0 regardless.
//  Scoreboard:
//   iss_en sets pending[iss_addr] at posedge.
//   Set and clear of the same addr in one cycle: set wins (newer producer).
//   ZERO_REG=1 and iss_addr=0: ignored.
//   rd_pend[r] = pending[rd_addr[r]] as registered; not bypassed.
//  Out of range (DEPTH not a power of 2, addr>=DEPTH):
//   write dropped, read returns 0, pend 0.
//  Reset asserted mid-sweep or mid-RUN: restarts the sweep from idx=0.
// STRUCTURE
//  Package regfile_pkg:
//   fsm typedef rf_state_e {RF_CLEAR, RF_RUN}.
//   helper function for bypass match.
//  Sub-module rf_scoreboard: pending bit vector, set/clear priority, NUM_RD lookup ports.
//  Array, write arbitration, bypass mux and clear FSM stay in regfile_mp.
// TESTING
//  1. Clear sweep: rst pulse, default params
//     -> ready=0 for exactly 32 cycles, then 1.
//     -> every rd_addr 0..31 reads 0x00000000.
//  2. Write/read, zero reg:
//     write 0xDEADBEEF to x5 and 0x12345678 to x0
//     -> next cycle x5 reads 0xDEADBEEF; x0 reads 0.
//  3. Bypass: BYPASS=1, wr x7=0xA5A5A5A5 while rd_addr[0]=7
//     -> same cycle rd_data=0xA5A5A5A5.
//     BYPASS=0 -> same cycle returns the old value, new value next cycle.
//  4. Multi-write: NUM_WR=2, both ports write x3 (0x1 on p0, 0x2 on p1)
//     -> x3=0x2.
//  5. Scoreboard: iss x9 -> rd_pend=1 next cycle.
//     Write x9 -> pend=0 next cycle.
//     iss x9 plus write x9 in the same cycle -> pend stays 1.
//  6. clr_req with x5=0xDEADBEEF and x9 pending
//     -> ready drops, after 32 cycles x5=0 and pend=0.
//     rst asserted at sweep idx 10 -> sweep restarts, ready 32 cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
//   rf_state_e  : clear-sweep / run state of the array controller
//   rf_aw       : address width for a given depth (minimum 1 bit)
//   rf_in_range : address lies inside the populated entries
//   rf_hit      : enabled write port targets the given read address
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    function automatic int rf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic rf_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

    function automatic logic rf_hit(input logic en, input logic [31:0] wa, input logic [31:0] ra);
        return en && (wa == ra);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback side bus of the register file.
//   clr_req/ready        : clear-sweep request and run indication
//   wr_en/wr_addr/wr_data: flat write ports, port p at [p*AW +: AW] / [p*XLEN +: XLEN]
//   rd_addr/rd_data      : flat combinational read ports
//   iss_en/iss_addr      : mark a destination pending at issue
//   rd_pend              : pending bit per read port
// master = pipeline side, slave = register file.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = regfile_pkg::rf_aw(DEPTH);

    logic                   clr_req;
    logic                   ready;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [NUM_RD-1:0]      rd_pend;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
        input  ready, rd_data, rd_pend
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
        output ready, rd_data, rd_pend
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-entry pending bits for outstanding results.
//   flush          : clear every pending bit
//   set_en/set_addr: mark an entry pending (wins over a same-edge clear)
//   clr_en/clr_addr: per write port, pre-qualified clears
//   rd_addr/rd_pend: registered pending bit of each read address
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic [NUM_WR-1:0]    clr_en,
    input  logic [NUM_WR*AW-1:0] clr_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_pend
);
    logic [DEPTH-1:0] pend;
    logic             set_ok;

    assign set_ok = set_en && rf_in_range(32'(set_addr), DEPTH)
                    && !(ZERO_REG != 0 && set_addr == '0);

    // Set is applied after the clears so a new producer overrides a retiring one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (clr_en[p]) pend[clr_addr[p*AW +: AW]] <= 1'b0;
            end
            if (set_ok) pend[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_pend = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            if (rf_in_range(32'(rd_addr[r*AW +: AW]), DEPTH))
                rd_pend[r] = pend[rd_addr[r*AW +: AW]];
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : regfile_mp_if slave (reads, writes, issue, clear sweep)
// After reset or clr_req the array is zeroed one entry per cycle; ready is
// low and all outputs read as zero until the sweep completes.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = rf_aw(DEPTH);

    rf_state_e              state;
    logic [AW-1:0]          idx;
    logic                   ready_q;
    logic                   run;
    logic [XLEN-1:0]        mem [DEPTH];
    logic [NUM_WR-1:0]      wr_ok;
    logic [NUM_RD-1:0]      pend_raw;
    logic [NUM_RD*XLEN-1:0] rd_data_c;
    logic [AW-1:0]          ra;
    logic [XLEN-1:0]        val;

    assign run = (state == RF_RUN);

    always_comb begin
        wr_ok = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            wr_ok[p] = run && bus.wr_en[p]
                       && rf_in_range(32'(bus.wr_addr[p*AW +: AW]), DEPTH)
                       && !(ZERO_REG != 0 && bus.wr_addr[p*AW +: AW] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RF_CLEAR;
            idx     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (idx == AW'(DEPTH - 1)) begin
                        state   <= RF_RUN;
                        idx     <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RF_RUN: begin
                    if (bus.clr_req) begin
                        state   <= RF_CLEAR;
                        idx     <= '0;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array has no reset; the sweep provides the initial contents.
    // Later ports overwrite earlier ones, so the highest port wins.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[idx] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p]) mem[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        ra        = '0;
        val       = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            ra  = bus.rd_addr[r*AW +: AW];
            val = '0;
            if (run && rf_in_range(32'(ra), DEPTH) && !(ZERO_REG != 0 && ra == '0)) begin
                val = mem[ra];
                if (BYPASS != 0) begin
                    for (int unsigned p = 0; p < NUM_WR; p++) begin
                        if (rf_hit(wr_ok[p], 32'(bus.wr_addr[p*AW +: AW]), 32'(ra)))
                            val = bus.wr_data[p*XLEN +: XLEN];
                    end
                end
            end
            rd_data_c[r*XLEN +: XLEN] = val;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (run && bus.clr_req),
        .set_en   (run && bus.iss_en),
        .set_addr (bus.iss_addr),
        .clr_en   (wr_ok),
        .clr_addr (bus.wr_addr),
        .rd_addr  (bus.rd_addr),
        .rd_pend  (pend_raw)
    );

    assign bus.ready   = ready_q;
    assign bus.rd_data = rd_data_c;
    assign bus.rd_pend = run ? pend_raw : '0;
endmodule
